core_mem_port: RTL and testbench

- Per-core load/store initiator that drives one port of the dual-core data memory: dataADDRn, dataINn, dataLoad[n], dataWrite[n] out; dataOUTn back in.
- Accepts CPU pipeline requests over a valid/ready handshake and buffers them in a small in-order FIFO.
- Issues each request as a one-cycle strobe, captures read data, and returns one in-order response per request.
- Enforces the idle cycle the memory needs to drain a serialized shared-region write. One instance per core.

---
 rtl/core_mem_port_if.sv | 33 +++
 rtl/core_mem_port.sv | 168 ++++++++++++++++
 tb/tb_core_mem_port.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_port_if.sv
// Bundle between a CPU pipeline, the core_mem_port initiator and one data-memory port.
// The slave modport is the initiator's view; master is the pipeline/memory environment.
interface core_mem_port_if #(
  parameter int unsigned TAM = 16
);
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [TAM-1:0] req_addr;
  logic [TAM-1:0] req_wdata;

  logic           rsp_valid;
  logic [TAM-1:0] rsp_rdata;
  logic           rsp_err;

  logic [TAM-1:0] mem_addr;
  logic [TAM-1:0] mem_wdata;
  logic           mem_load;
  logic           mem_write;
  logic [TAM-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_wdata, mem_load, mem_write
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_wdata, mem_load, mem_write
  );
endinterface

// File: rtl/core_mem_port.sv
// Per-core load/store initiator: queues pipeline requests, strobes one memory access per
// cycle, returns in-order responses and idles after shared-region writes.
module core_mem_port #(
  parameter int unsigned TAM        = 16,
  parameter int unsigned Lmem       = 8,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned SHWR_GAP   = 1
) (
  input logic           clk,
  input logic           rst,
  core_mem_port_if.slave bus
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned GW = $clog2(SHWR_GAP + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_e;

  state_e         state_q, state_d;

  logic           fifo_we_q    [FIFO_DEPTH];
  logic [TAM-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [TAM-1:0] fifo_wdata_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;

  logic [GW-1:0]  gap_q, gap_d;

  logic           cur_we_q,  cur_we_d;
  logic           cur_err_q, cur_err_d;
  logic           cur_sh_q,  cur_sh_d;

  logic [TAM-1:0] mem_addr_q,  mem_addr_d;
  logic [TAM-1:0] mem_wdata_q, mem_wdata_d;
  logic           mem_load_q,  mem_load_d;
  logic           mem_write_q, mem_write_d;

  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_err_q,   rsp_err_d;
  logic [TAM-1:0] rsp_rdata_q, rsp_rdata_d;

  logic           full, empty, push, pop;
  logic           head_we, head_err, head_sh;
  logic [TAM-1:0] head_addr, head_wdata;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.req_valid & ~full;

  assign head_we    = fifo_we_q[rd_ptr_q];
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_wdata = fifo_wdata_q[rd_ptr_q];
  assign head_err   = ((head_addr >> (Lmem + 1)) != '0);
  assign head_sh    = head_addr[Lmem];

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    cur_we_d    = cur_we_q;
    cur_err_d   = cur_err_q;
    cur_sh_d    = cur_sh_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_load_d  = 1'b0;
    mem_write_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    pop         = 1'b0;

    unique case (state_q)
      S_IDLE: ;
      S_ISSUE: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = cur_err_q;
        if (!cur_err_q && !cur_we_q) rsp_rdata_d = bus.mem_rdata;
        state_d = S_IDLE;
        if (cur_we_q && cur_sh_q && !cur_err_q) begin
          gap_d   = GW'(SHWR_GAP);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q <= GW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Completion and the next issue share an edge unless a shared write opens a gap.
    if (state_q != S_GAP && state_d != S_GAP && gap_q == '0 && !empty) begin
      pop       = 1'b1;
      state_d   = S_ISSUE;
      cur_we_d  = head_we;
      cur_err_d = head_err;
      cur_sh_d  = head_sh;
      if (!head_err) begin
        mem_addr_d  = head_addr;
        mem_wdata_d = head_wdata;
        mem_write_d = head_we;
        mem_load_d  = ~head_we;
      end
    end
  end

  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      gap_q       <= '0;
      cur_we_q    <= 1'b0;
      cur_err_q   <= 1'b0;
      cur_sh_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_load_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q     <= count_d;
      gap_q       <= gap_d;
      cur_we_q    <= cur_we_d;
      cur_err_q   <= cur_err_d;
      cur_sh_q    <= cur_sh_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_load_q  <= mem_load_d;
      mem_write_q <= mem_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we_q[wr_ptr_q]    <= bus.req_we;
      fifo_addr_q[wr_ptr_q]  <= bus.req_addr;
      fifo_wdata_q[wr_ptr_q] <= bus.req_wdata;
    end
  end

  assign bus.req_ready = ~full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_load  = mem_load_q;
  assign bus.mem_write = mem_write_q;

  a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(mem_load_q && mem_write_q));
  a_gap_idle:    assert property (@(posedge clk) disable iff (rst)
                                  (state_q == S_GAP) |-> !(mem_load_q || mem_write_q));
endmodule

// File: tb/tb_core_mem_port.sv
// Bench for core_mem_port: emulated data memory on the falling edge, queue scoreboard of
// expected in-order responses, directed scenarios plus a randomized request mix.
module tb_core_mem_port;
  localparam int unsigned TAM   = 16;
  localparam int unsigned LMEM  = 8;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned GAP   = 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic [15:0] rdata;
  } rsp_t;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   both_cnt = 0;

  logic [15:0] env_mem [512];
  logic [15:0] ref_mem [512];
  rsp_t        got_q [$];
  exp_t        exp_q [$];
  int          wr_log [$];
  int          ld_log [$];
  logic [15:0] ld_addr_log [$];

  core_mem_port_if #(.TAM(TAM)) bus ();

  core_mem_port #(
    .TAM(TAM), .Lmem(LMEM), .FIFO_DEPTH(DEPTH), .SHWR_GAP(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory acts on the falling edge inside the strobe cycle; also logs DUT activity.
  always @(negedge clk) begin
    if (bus.mem_write && bus.mem_load) both_cnt++;
    if (bus.mem_write) begin
      env_mem[bus.mem_addr[8:0]] = bus.mem_wdata;
      wr_log.push_back(cyc);
    end
    if (bus.mem_load) begin
      bus.mem_rdata = env_mem[bus.mem_addr[8:0]];
      ld_log.push_back(cyc);
      ld_addr_log.push_back(bus.mem_addr);
    end
    if (bus.rsp_valid) got_q.push_back('{cyc: cyc, err: bus.rsp_err, rdata: bus.rsp_rdata});
  end

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    wr_log.delete();
    ld_log.delete();
    ld_addr_log.delete();
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves req_valid high so successive calls present requests back to back.
  task automatic push_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          output int acc_cyc);
    bit done = 1'b0;
    acc_cyc = -1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = bus.req_ready;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout addr %h not accepted within 50 cycles", addr);
    end else begin
      acc_cyc = cyc;
      if (addr[15:9] != 7'd0) exp_q.push_back('{err: 1'b1, rdata: 16'h0});
      else if (we) begin
        ref_mem[addr[8:0]] = wdata;
        exp_q.push_back('{err: 1'b0, rdata: 16'h0});
      end else exp_q.push_back('{err: 1'b0, rdata: ref_mem[addr[8:0]]});
    end
  endtask

  task automatic wait_rsp(input int n, input string name);
    int k = 0;
    bus.req_valid = 1'b0;
    while (got_q.size() < n && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    idle(4);
    checks++;
    if (got_q.size() != n) begin
      errors++;
      $display("FAIL %s_count got %0d responses required %0d", name, got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", bus.req_ready); end
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.mem_load, bus.mem_write} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 0000", {bus.rsp_valid, bus.rsp_err, bus.mem_load, bus.mem_write});
    end
    checks++;
    if ({bus.rsp_rdata, bus.mem_addr, bus.mem_wdata} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data got %h required 0", {bus.rsp_rdata, bus.mem_addr, bus.mem_wdata});
    end
    rst = 1'b0;
    idle(2);
    clear_logs();
  endtask

  task automatic test_store_load();
    int p0, p1;
    exp_t e;
    clear_logs();
    push_req(1'b1, 16'h0005, 16'hBEEF, p0);
    push_req(1'b0, 16'h0005, 16'h0000, p1);
    wait_rsp(2, "store_load");
    checks++;
    if (got_q[0].cyc !== p0 + 2) begin errors++; $display("FAIL sl_latency got %0d required %0d", got_q[0].cyc, p0 + 2); end
    checks++;
    if (got_q[1].cyc !== p0 + 3) begin errors++; $display("FAIL sl_second_cyc got %0d required %0d", got_q[1].cyc, p0 + 3); end
    checks++;
    if (got_q[1].rdata !== 16'hBEEF) begin errors++; $display("FAIL sl_readback got %h required BEEF", got_q[1].rdata); end
    checks++;
    if (wr_log.size() != 1 || ld_log.size() != 1) begin
      errors++;
      $display("FAIL sl_strobes got write %0d load %0d required 1 1", wr_log.size(), ld_log.size());
    end
    foreach (got_q[i]) begin
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL sl_extra response %0d unexpected", i); end
      else begin
        e = exp_q.pop_front();
        if (got_q[i].err !== e.err || got_q[i].rdata !== e.rdata) begin
          errors++;
          $display("FAIL sl_rsp%0d got err %b data %h required err %b data %h", i, got_q[i].err, got_q[i].rdata, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic test_shared_gap();
    int p0, p1;
    exp_t e;
    clear_logs();
    push_req(1'b1, 16'h0110, 16'h1234, p0);
    push_req(1'b0, 16'h0110, 16'h0000, p1);
    wait_rsp(2, "shared_gap");
    checks++;
    if (wr_log.size() != 1 || ld_log.size() != 1) begin
      errors++;
      $display("FAIL gap_strobes got write %0d load %0d required 1 1", wr_log.size(), ld_log.size());
    end else begin
      checks++;
      if (ld_log[0] !== wr_log[0] + 2 + GAP) begin
        errors++;
        $display("FAIL gap_timing load cycle %0d required %0d", ld_log[0], wr_log[0] + 2 + GAP);
      end
    end
    checks++;
    if (got_q[1].rdata !== 16'h1234) begin errors++; $display("FAIL gap_readback got %h required 1234", got_q[1].rdata); end
    foreach (got_q[i]) begin
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL gap_extra response %0d unexpected", i); end
      else begin
        e = exp_q.pop_front();
        if (got_q[i].err !== e.err || got_q[i].rdata !== e.rdata) begin
          errors++;
          $display("FAIL gap_rsp%0d got err %b data %h required err %b data %h", i, got_q[i].err, got_q[i].rdata, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int p0, pn;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      env_mem[i] = 16'h00A0 + 16'(i);
      ref_mem[i] = 16'h00A0 + 16'(i);
    end
    push_req(1'b0, 16'h0000, 16'h0, p0);
    for (int i = 1; i < 4; i++) push_req(1'b0, 16'(i), 16'h0, pn);
    wait_rsp(4, "b2b");
    checks++;
    if (got_q[0].cyc !== p0 + 2) begin errors++; $display("FAIL b2b_latency got %0d required %0d", got_q[0].cyc, p0 + 2); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_q[i].cyc !== got_q[0].cyc + i || got_q[i].rdata !== 16'h00A0 + 16'(i) || got_q[i].err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_rsp%0d got cyc %0d data %h err %b required cyc %0d data %h err 0",
                 i, got_q[i].cyc, got_q[i].rdata, got_q[i].err, got_q[0].cyc + i, 16'h00A0 + 16'(i));
      end
    end
    exp_q.delete();
  endtask

  task automatic test_addr_err();
    int p0, p1;
    exp_t e;
    clear_logs();
    push_req(1'b0, 16'h0200, 16'h0, p0);
    push_req(1'b0, 16'h0003, 16'h0, p1);
    wait_rsp(2, "addr_err");
    checks++;
    if (got_q[0].cyc !== p0 + 2 || got_q[0].err !== 1'b1 || got_q[0].rdata !== 16'h0) begin
      errors++;
      $display("FAIL err_rsp got cyc %0d err %b data %h required cyc %0d err 1 data 0000", got_q[0].cyc, got_q[0].err, got_q[0].rdata, p0 + 2);
    end
    checks++;
    if (wr_log.size() != 0 || ld_log.size() != 1 || ld_addr_log[0] !== 16'h0003) begin
      errors++;
      $display("FAIL err_strobes got write %0d load %0d required 0 1 at 0003", wr_log.size(), ld_log.size());
    end
    foreach (got_q[i]) begin
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL err_extra response %0d unexpected", i); end
      else begin
        e = exp_q.pop_front();
        if (got_q[i].err !== e.err || got_q[i].rdata !== e.rdata) begin
          errors++;
          $display("FAIL err_rsp%0d got err %b data %h required err %b data %h", i, got_q[i].err, got_q[i].rdata, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int ps, a1, a2, a3;
    exp_t e;
    clear_logs();
    push_req(1'b1, 16'h0150, 16'h5A5A, ps);
    push_req(1'b0, 16'h0150, 16'h0, a1);
    push_req(1'b0, 16'h0004, 16'h0, a2);
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b required 0", bus.req_ready); end
    push_req(1'b0, 16'h0005, 16'h0, a3);
    wait_rsp(4, "backpressure");
    checks++;
    if (ld_log.size() == 0 || a3 <= ld_log[0]) begin
      errors++;
      $display("FAIL bp_accept third accepted at %0d, first load at %0d", a3, (ld_log.size() != 0) ? ld_log[0] : -1);
    end
    checks++;
    if (a3 !== ps + 4 + GAP) begin errors++; $display("FAIL bp_accept_cyc got %0d required %0d", a3, ps + 4 + GAP); end
    foreach (got_q[i]) begin
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra response %0d unexpected", i); end
      else begin
        e = exp_q.pop_front();
        if (got_q[i].err !== e.err || got_q[i].rdata !== e.rdata) begin
          errors++;
          $display("FAIL bp_rsp%0d got err %b data %h required err %b data %h", i, got_q[i].err, got_q[i].rdata, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic test_random();
    int acc, r, n;
    logic [15:0] addr;
    exp_t e;
    clear_logs();
    n = 0;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      addr = 16'($urandom_range(0, 15));
      else if (r < 8) addr = 16'h0100 | 16'($urandom_range(0, 15));
      else            addr = 16'h0200 + 16'($urandom_range(0, 16'hFDFF));
      push_req(1'($urandom_range(0, 1)), addr, 16'($urandom), acc);
      if (acc >= 0) n++;
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    wait_rsp(n, "random");
    foreach (got_q[i]) begin
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_extra response %0d unexpected", i); end
      else begin
        e = exp_q.pop_front();
        if (got_q[i].err !== e.err || got_q[i].rdata !== e.rdata) begin
          errors++;
          $display("FAIL rnd_rsp%0d got err %b data %h required err %b data %h", i, got_q[i].err, got_q[i].rdata, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int ps, a1, a2, n0, nl, nw;
    clear_logs();
    push_req(1'b1, 16'h0120, 16'h7777, ps);
    push_req(1'b0, 16'h0001, 16'h0, a1);
    push_req(1'b0, 16'h0002, 16'h0, a2);
    bus.req_addr = 16'h0003;
    bus.req_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.mem_load !== 1'b1) begin errors++; $display("FAIL rm_in_issue mem_load got %b required 1", bus.mem_load); end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.mem_load, bus.mem_write, bus.req_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL rm_async_ctrl got %b required 00001", {bus.rsp_valid, bus.rsp_err, bus.mem_load, bus.mem_write, bus.req_ready});
    end
    checks++;
    if ({bus.rsp_rdata, bus.mem_addr, bus.mem_wdata} !== 48'h0) begin
      errors++;
      $display("FAIL rm_async_data got %h required 0", {bus.rsp_rdata, bus.mem_addr, bus.mem_wdata});
    end
    bus.req_valid = 1'b0;
    n0 = got_q.size();
    nl = ld_log.size();
    nw = wr_log.size();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);
    checks++;
    if (got_q.size() != n0 || ld_log.size() != nl || wr_log.size() != nw) begin
      errors++;
      $display("FAIL rm_no_activity got rsp %0d load %0d write %0d required %0d %0d %0d",
               got_q.size(), ld_log.size(), wr_log.size(), n0, nl, nw);
    end
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 512; i++) begin
      v = 16'($urandom);
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    test_reset();
    test_store_load();
    test_shared_gap();
    test_back_to_back();
    test_addr_err();
    test_backpressure();
    test_random();
    test_reset_mid();
    checks++;
    if (both_cnt != 0) begin errors++; $display("FAIL strobe_excl both strobes high %0d times required 0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end
endmodule
